temp_freq_meter: RTL
====================

// Module: temp_freq_meter
// PURPOSE
//  Gated frequency counter for the on-chip temperature-sensor VCO output (the common Fvco/v9m net).
//  Counts rising VCO edges over a programmable window of wb_clk_i cycles and pushes each count into a small result FIFO.
//  The management SoC reads the FIFO over the Wishbone slave port, and an interrupt flags available data.
//  Sits directly downstream of the analog VCO macro, in parallel with temp_digital.
// PARAMETERS
//  BASE_ADDR   32'h3000_0000  Wishbone base address; the block decodes 4 words at BASE_ADDR..BASE_ADDR+0xC.
//  CNT_W       24             edge-counter and result width; a count saturates at 2**CNT_W-1.
//  DEPTH       4              result FIFO depth; must be a power of 2, >= 2.
//  GATE_RST    32'd10000      reset value of the GATE register.
// PORTS
//  wb_clk_i     in   1      single clock; all logic is in this domain.
//  wb_rst_n_i   in   1      synchronous reset, active-low.
//  vco_i        in   1      asynchronous VCO square wave; must be slower than wb_clk_i/2.
//  wbs_cyc_i    in   1      Wishbone cycle.
//  wbs_stb_i    in   1      Wishbone strobe.
//  wbs_we_i     in   1      Wishbone write enable.
//  wbs_sel_i    in   4      byte selects; writes honour them per byte.
//  wbs_adr_i    in   32     byte address.
//  wbs_dat_i    in   32     write data.
//  wbs_ack_o    out  1      Wishbone acknowledge.
//  wbs_dat_o    out  32     read data.
//  irq_o        out  1      level interrupt: irq_en & (fifo not empty | ovf).
// BEHAVIOUR
//  Reset
//   - All outputs are 0. FSM = IDLE, FIFO empty.
//   - CTRL=0, GATE=GATE_RST, ovf=0.
//   - The synchronizer flops also reset to 0.
//  Input path
//   - vco_i passes through a 2-flop synchronizer plus one delay flop.
//   - rise = s2 & ~s3. Latency from vco_i to rise is 2-3 cycles.
//  Registers (index = adr[3:2]; a hit needs adr[31:4]==BASE_ADDR[31:4])
//   - 0 CTRL, RW: b0 start, b1 cont, b2 irq_en, b3 clr.
//     - b0 self-clears on the next cycle and reads 0.
//     - b3 is write-1 pulse: empties the FIFO and clears ovf.
//   - 1 GATE, RW: window length in cycles. A value of 0 is treated as 1.
//   - 2 STATUS, RO: b0 busy, b1 empty, b2 full, b3 ovf, b4 sat_last, b[11:8] fifo count.
//   - 3 DATA, RO: FIFO head, zero-extended to 32 bits.
//     - A read pops the head.
//     - Reading while empty returns 0 and does not pop.
//  Wishbone handshake
//   - wbs_ack_o <= hit & cyc & stb & ~wbs_ack_o, so ack arrives 1 cycle after the request, lasts exactly 1 cycle, then there is a 1-cycle gap.
//   - The register write or FIFO pop takes effect on the ack cycle.
//   - wbs_dat_o is valid with ack and is 0 otherwise.
//   - A non-hit address gets no ack.
//  FSM
//   - IDLE -> COUNT on start. On entry, cnt=0 and gate_ctr=GATE (or 1 if GATE is 0).
//   - COUNT, each cycle: gate_ctr--, and cnt++ on rise (held at all-ones once saturated).
//     - Leaves for STORE in the cycle gate_ctr reaches 1, so the window is exactly GATE cycles and a rise in the last cycle is counted.
//   - STORE, 1 cycle: push cnt and latch sat_last. Then go to COUNT (reloaded, with no dead cycle between windows) if cont, else IDLE.
//   - busy = (state != IDLE).
//   - Clearing cont mid-window lets the current window finish, then the FSM goes to IDLE.
//   - A start write while busy is ignored.
//   - A GATE write while busy applies to the next window.
//  FIFO
//   - Push when full: the new sample is dropped and ovf is set (sticky until clr).
//   - Push and pop in the same cycle: both happen, count is unchanged; if full, there is no ovf.
//   - clr in the same cycle as a push: clr wins and the sample is discarded.
//   - clr also aborts a running window (FSM goes to IDLE).
//  Reset mid-window: everything returns to reset values and no partial count is stored.
// STRUCTURE
//  - Package temp_fm_pkg: register index localparams, CTRL/STATUS bit positions, FSM state enum (IDLE, COUNT, STORE).
//  - One sub-module: temp_fm_fifo, a synchronous FIFO of DEPTH x CNT_W with push/pop/clr, full/empty/count and drop-on-full.
//  - Synchronizer, counter, FSM and Wishbone decode stay in the top level.
// TESTING
//  1. vco_i = wb_clk_i/10, GATE=1000, start -> DATA reads 100 +/-1; STATUS.busy=0 afterwards; irq_o=1 when irq_en=1 and clears after the pop.
//  2. GATE=0, start with vco_i toggling -> a 1-cycle window; the stored count is 0 or 1; the FSM returns to IDLE after 2 busy cycles.
//  3. CNT_W=4, vco_i=wb_clk_i/4, GATE=200 -> DATA=15 and STATUS.sat_last=1.
//  4. cont=1, GATE=50, with no reads -> after 5 windows count=4, full=1, ovf=1; DATA pops windows 1-4 in order. Then write clr -> empty=1, ovf=0.
//  5. Assert wb_rst_n_i low mid-window -> the next cycle shows all outputs 0 and GATE=GATE_RST; no sample appears after release.
//  6. Wishbone: held stb/cyc gives ack pulses 1 cycle on, 1 off; an address outside BASE_ADDR..+0xC never acks; a sel=4'b0001 write to GATE changes only bits [7:0].

Source files
------------

// File: rtl/temp_fm_pkg.sv
// Shared definitions for the temperature-sensor VCO frequency meter:
// register map, CTRL/STATUS bit positions and the measurement FSM states.
package temp_fm_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_GATE   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_DATA   = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_CLR    = 3;

  localparam int ST_BUSY    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_FULL    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_SAT     = 4;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    STORE = 2'd2
  } state_e;

endpackage

// File: rtl/temp_fm_fifo.sv
// Result FIFO for the frequency meter: drops a push when full and raises a
// sticky overflow flag; clr empties it and wins over a simultaneous push.
module temp_fm_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clr_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     ovf_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic          doPush, doPop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign ovf_o   = ovf_q;
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign doPush = push_i & (~full_o | pop_i) & ~clr_i;
  assign doPop  = pop_i & ~empty_o & ~clr_i;

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_q + (AW+1)'(doPush) - (AW+1)'(doPop);
      if (push_i && full_o && !pop_i) ovf_q <= 1'b1;
    end
  end

endmodule

// File: rtl/temp_freq_meter.sv
// Gated frequency counter for the temperature-sensor VCO: counts synchronized
// VCO rising edges over GATE clock cycles and queues results for Wishbone reads.
module temp_freq_meter
  import temp_fm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          CNT_W     = 24,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] GATE_RST  = 32'd10000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        vco_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             vcoS1_q, vcoS2_q, vcoS3_q, rise;
  logic             ack_q, start_q, cont_q, irqEn_q;
  logic [31:0]      gate_q, gateLoad;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      gateCtr_q;
  logic             satLast_q;
  logic             hit, req, wrEn, rdEn, ctrlWr, gateWr, clr, push, pop;
  logic [1:0]       regIdx;
  logic [CNT_W-1:0] fifoData;
  logic             fifoFull, fifoEmpty, fifoOvf;
  logic [CW-1:0]    fifoCount;
  logic [31:0]      statusWord, rdata;
  logic             unused_ok;

  assign unused_ok = ^wbs_adr_i[1:0];

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      vcoS1_q <= 1'b0;
      vcoS2_q <= 1'b0;
      vcoS3_q <= 1'b0;
    end else begin
      vcoS1_q <= vco_i;
      vcoS2_q <= vcoS1_q;
      vcoS3_q <= vcoS2_q;
    end
  end
  assign rise = vcoS2_q & ~vcoS3_q;

  assign hit    = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign req    = hit & wbs_cyc_i & wbs_stb_i;
  assign regIdx = wbs_adr_i[3:2];
  // Writes and pops commit on the ack cycle, while the master still holds the request
  assign wrEn   = ack_q & req & wbs_we_i;
  assign rdEn   = ack_q & req & ~wbs_we_i;
  assign ctrlWr = wrEn & (regIdx == REG_CTRL) & wbs_sel_i[0];
  assign gateWr = wrEn & (regIdx == REG_GATE);
  assign clr    = ctrlWr & wbs_dat_i[CTRL_CLR];
  assign pop    = rdEn & (regIdx == REG_DATA) & ~fifoEmpty;
  assign push   = (state_q == STORE);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      ack_q   <= 1'b0;
      start_q <= 1'b0;
      cont_q  <= 1'b0;
      irqEn_q <= 1'b0;
      gate_q  <= GATE_RST;
    end else begin
      ack_q   <= req & ~ack_q;
      start_q <= ctrlWr & wbs_dat_i[CTRL_START];
      if (ctrlWr) begin
        cont_q  <= wbs_dat_i[CTRL_CONT];
        irqEn_q <= wbs_dat_i[CTRL_IRQ_EN];
      end
      if (gateWr) begin
        for (int b = 0; b < 4; b++) begin
          if (wbs_sel_i[b]) gate_q[8*b +: 8] <= wbs_dat_i[8*b +: 8];
        end
      end
    end
  end

  assign gateLoad = (gate_q == '0) ? 32'd1 : gate_q;
  assign cnt_d    = (rise && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gateCtr_q <= '0;
      satLast_q <= 1'b0;
    end else if (clr) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_q) begin
            state_q   <= COUNT;
            cnt_q     <= '0;
            gateCtr_q <= gateLoad;
          end
        end
        COUNT: begin
          gateCtr_q <= gateCtr_q - 32'd1;
          cnt_q     <= cnt_d;
          if (gateCtr_q == 32'd1) state_q <= STORE;
        end
        STORE: begin
          satLast_q <= &cnt_q;
          if (cont_q) begin
            state_q   <= COUNT;
            cnt_q     <= '0;
            gateCtr_q <= gateLoad;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  temp_fm_fifo #(
    .DEPTH (DEPTH),
    .W     (CNT_W)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_n_i (wb_rst_n_i),
    .push_i  (push),
    .pop_i   (pop),
    .clr_i   (clr),
    .data_i  (cnt_q),
    .data_o  (fifoData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .ovf_o   (fifoOvf),
    .count_o (fifoCount)
  );

  always_comb begin
    statusWord = '0;
    statusWord[ST_BUSY]  = (state_q != IDLE);
    statusWord[ST_EMPTY] = fifoEmpty;
    statusWord[ST_FULL]  = fifoFull;
    statusWord[ST_OVF]   = fifoOvf;
    statusWord[ST_SAT]   = satLast_q;
    statusWord[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(fifoCount);
  end

  always_comb begin
    rdata = '0;
    case (regIdx)
      REG_CTRL:   rdata = {29'd0, irqEn_q, cont_q, 1'b0};
      REG_GATE:   rdata = gate_q;
      REG_STATUS: rdata = statusWord;
      REG_DATA:   rdata = fifoEmpty ? 32'd0 : 32'(fifoData);
      default:    rdata = '0;
    endcase
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = ack_q ? rdata : 32'd0;
  assign irq_o     = irqEn_q & (~fifoEmpty | fifoOvf);

endmodule
